button_event_decoder: RTL and testbench

- Consumer end of the button path: takes the clean, already-debounced button level and classifies each user action as a short press, long press or double press.
- Emits one-cycle event strobes, a held indicator and a wrapping event counter for the top-level mode/LED logic.
- All timing comes from an internal tick prescaler, so thresholds are expressed in ticks rather than raw clocks.

---
 rtl/button_event_decoder_pkg.sv | 13 +
 rtl/button_event_decoder_tick_gen.sv | 18 +
 rtl/button_event_decoder.sv | 70 +++++++
 tb/tb_button_event_decoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_decoder_pkg.sv
// button_event_decoder_pkg: shared state encoding and default timing constants for the button decoder
package button_event_decoder_pkg;
  localparam logic [2:0] ARM    = 3'd0;
  localparam logic [2:0] IDLE   = 3'd1;
  localparam logic [2:0] PRESS1 = 3'd2;
  localparam logic [2:0] LHELD  = 3'd3;
  localparam logic [2:0] GAP    = 3'd4;
  localparam logic [2:0] WREL   = 3'd5;
  localparam int DEF_TICK_DIV   = 6;
  localparam int DEF_LONG_TICKS = 8;
  localparam int DEF_GAP_TICKS  = 4;
  localparam int DEF_CNT_W      = 8;
endpackage

// File: rtl/button_event_decoder_tick_gen.sv
// tick_gen: free-running prescaler raising a one-cycle tick every TICK_DIV clocks
module tick_gen
  import button_event_decoder_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] presc;
  assign tick = presc == PW'(TICK_DIV - 1);
  // count 0..TICK_DIV-1 and wrap on the tick cycle
  always_ff @(posedge clk)
    if (rst) presc <= '0;
    else presc <= tick ? '0 : presc + 1'b1;
endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: classifies debounced button actions into short, long and double press strobes
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int LONG_TICKS = DEF_LONG_TICKS,
  parameter int GAP_TICKS  = DEF_GAP_TICKS,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  output logic             short_press,
  output logic             long_press,
  output logic             double_press,
  output logic             held,
  output logic [CNT_W-1:0] event_count
);
  localparam int TMAX = LONG_TICKS > GAP_TICKS ? LONG_TICKS : GAP_TICKS;
  localparam int TW = $clog2(TMAX + 1);
  logic btn_q, tick, long_hit, gap_hit, short_n, long_n, double_n;
  logic [2:0] state, state_n;
  logic [TW-1:0] timer;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  assign long_hit = tick && timer == TW'(LONG_TICKS - 1);
  assign gap_hit = tick && timer == TW'(GAP_TICKS - 1);
  assign held = btn_q && state != ARM;
  // btn_q keeps tracking btn through reset so a press held across reset stays visible to ARM
  always_ff @(posedge clk) btn_q <= btn;
  // next state and strobe decisions; release beats the long threshold, a new press beats gap expiry
  always_comb begin
    state_n = state;
    short_n = 1'b0;
    long_n = 1'b0;
    double_n = 1'b0;
    case (state)
      ARM:    state_n = btn_q ? ARM : IDLE;
      IDLE:   state_n = btn_q ? PRESS1 : IDLE;
      PRESS1: begin
        long_n = btn_q && long_hit;
        state_n = !btn_q ? GAP : long_hit ? LHELD : PRESS1;
      end
      LHELD:  state_n = btn_q ? LHELD : IDLE;
      GAP:    begin
        double_n = btn_q;
        short_n = !btn_q && gap_hit;
        state_n = btn_q ? WREL : gap_hit ? IDLE : GAP;
      end
      WREL:   state_n = btn_q ? WREL : IDLE;
      default: state_n = ARM;
    endcase
  end
  // state, saturating tick timer cleared on each state change, registered strobes and event counter
  always_ff @(posedge clk)
    if (rst) begin
      state <= ARM;
      timer <= '0;
      short_press <= 1'b0;
      long_press <= 1'b0;
      double_press <= 1'b0;
      event_count <= '0;
    end else begin
      state <= state_n;
      timer <= state_n != state ? '0 : (tick && timer != TW'(TMAX)) ? timer + 1'b1 : timer;
      short_press <= short_n;
      long_press <= long_n;
      double_press <= double_n;
      event_count <= event_count + CNT_W'(short_n | long_n | double_n);
    end
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: randomized and directed checks of the button decoder against an interval-based model
module tb_button_event_decoder;
  localparam int TD = 2, LT = 4, GT = 3, MAXN = 400;
  logic clk = 0, rst = 1, btn = 0;
  logic sp, lp, dp, hd, sp2, lp2, dp2, hd2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
  int n_cmp = 0, n_bad = 0, n;
  bit bq[$];
  bit q[MAXN+1];
  logic [2:0] obs_st[MAXN+1], exp_st[MAXN+1];
  logic obs_h[MAXN+1];
  logic [7:0] obs_c[MAXN+1];
  logic [1:0] obs_c2[MAXN+1];

  always #5 clk = ~clk;

  button_event_decoder #(.TICK_DIV(TD), .LONG_TICKS(LT), .GAP_TICKS(GT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .btn(btn), .short_press(sp), .long_press(lp),
    .double_press(dp), .held(hd), .event_count(cnt));
  button_event_decoder #(.TICK_DIV(TD), .LONG_TICKS(LT), .GAP_TICKS(GT), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .btn(btn), .short_press(sp2), .long_press(lp2),
    .double_press(dp2), .held(hd2), .event_count(cnt2));

  task automatic add(input bit v, input int len);
    repeat (len) bq.push_back(v);
  endtask

  function automatic int first_q(input int from, input bit v);
    for (int k = from; k <= n; k++) if (q[k] == v) return k;
    return n + 1;
  endfunction

  function automatic int nth_tick(input int a, input int nn);
    return a + (TD - 1 - a % TD) + (nn - 1) * TD;
  endfunction

  task automatic mark(input int c, input int pos);
    if (c <= n) exp_st[c][pos] = 1'b1;
  endtask

  task automatic model();
    int i, r, f, l, g, s, gx;
    for (int k = 0; k <= n; k++) exp_st[k] = 3'b000;
    i = first_q(0, 0) + 1;
    while (i <= n) begin
      r = first_q(i, 1);
      if (r > n) break;
      f = first_q(r + 1, 0);
      l = nth_tick(r + 1, LT);
      if (l < f) begin
        mark(l + 1, 1);
        i = first_q(l + 1, 0) + 1;
      end else begin
        if (f > n) break;
        g = f + 1;
        s = first_q(g, 1);
        gx = nth_tick(g, GT);
        if (s <= gx) begin
          mark(s + 1, 0);
          i = first_q(s + 1, 0) + 1;
        end else begin
          mark(gx + 1, 2);
          i = gx + 1;
        end
      end
    end
  endtask

  task automatic rec(input int k);
    obs_st[k] = {sp, lp, dp};
    obs_h[k] = hd;
    obs_c[k] = cnt;
    obs_c2[k] = cnt2;
  endtask

  task automatic run_seq(input bit init);
    int ec, arm;
    n = bq.size() > MAXN ? MAXN : bq.size();
    @(negedge clk);
    rst = 1;
    btn = init;
    repeat (2) @(negedge clk);
    rst = 0;
    q[0] = init;
    rec(0);
    for (int k = 0; k < n; k++) begin
      btn = bq[k];
      q[k+1] = bq[k];
      @(posedge clk);
      #1 rec(k + 1);
      @(negedge clk);
    end
    bq.delete();
    model();
    arm = first_q(0, 0);
    ec = 0;
    for (int k = 0; k <= n; k++) begin
      ec += $countones(exp_st[k]);
      n_cmp += 5;
      if (obs_st[k] !== exp_st[k]) begin
        n_bad++;
        $display("FAIL strobes k=%0d got %b want %b", k, obs_st[k], exp_st[k]);
      end
      if ($countones(obs_st[k]) > 1) begin
        n_bad++;
        $display("FAIL onehot k=%0d got %b want at most one strobe", k, obs_st[k]);
      end
      if (obs_h[k] !== (q[k] && k > arm)) begin
        n_bad++;
        $display("FAIL held k=%0d got %b want %b", k, obs_h[k], q[k] && k > arm);
      end
      if (obs_c[k] !== 8'(ec)) begin
        n_bad++;
        $display("FAIL count k=%0d got %0d want %0d", k, obs_c[k], ec % 256);
      end
      if (obs_c2[k] !== 2'(ec)) begin
        n_bad++;
        $display("FAIL count2 k=%0d got %0d want %0d", k, obs_c2[k], ec % 4);
      end
    end
  endtask

  task automatic test_reset();
    int early, ns;
    add(0, 6);
    run_seq(0);
    n_cmp += 3;
    if (obs_st[0] !== 3'b000) begin n_bad++; $display("FAIL rst_strobes got %b want 000", obs_st[0]); end
    if (obs_c[0] !== 8'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", obs_c[0]); end
    if (obs_h[0] !== 1'b0) begin n_bad++; $display("FAIL rst_held got %b want 0", obs_h[0]); end
    add(0, 2);
    add(1, 5);
    run_seq(0);
    add(1, 20);
    add(0, 4);
    add(1, 3);
    add(0, 14);
    run_seq(1);
    early = 0;
    ns = 0;
    for (int k = 0; k <= n; k++) begin
      if (k <= 22 && obs_st[k] != 3'b000) early++;
      if (k <= 20 && obs_h[k] !== 1'b0) early++;
      if (obs_st[k][2]) ns++;
    end
    n_cmp += 3;
    if (early != 0) begin n_bad++; $display("FAIL held_thru_reset got %0d activity cycles want 0", early); end
    if (ns != 1) begin n_bad++; $display("FAIL reset_then_short got %0d shorts want 1", ns); end
    if (obs_c[n] !== 8'd1) begin n_bad++; $display("FAIL reset_count got %0d want 1", obs_c[n]); end
  endtask

  task automatic test_short();
    int ns = 0, no = 0, cs = -1;
    add(0, 3);
    add(1, 3);
    add(0, 14);
    run_seq(0);
    for (int k = 0; k <= n; k++) begin
      if (obs_st[k][2]) begin ns++; cs = k; end
      if (obs_st[k][1] || obs_st[k][0]) no++;
    end
    n_cmp += 3;
    if (ns != 1 || no != 0) begin n_bad++; $display("FAIL short_once got %0d short %0d other want 1 0", ns, no); end
    if (cs - 6 < 4 || cs - 6 > 10) begin n_bad++; $display("FAIL short_latency got %0d want 4..10", cs - 6); end
    if (obs_c[n] !== 8'd1) begin n_bad++; $display("FAIL short_count got %0d want 1", obs_c[n]); end
  endtask

  task automatic test_long();
    int nl = 0, no = 0, cl = -1, hb = 0;
    add(0, 3);
    add(1, 20);
    add(0, 10);
    run_seq(0);
    for (int k = 0; k <= n; k++) begin
      if (obs_st[k][1]) begin nl++; cl = k; end
      if (obs_st[k][2] || obs_st[k][0]) no++;
      if (k >= 4 && k <= 23 && obs_h[k] !== 1'b1) hb++;
    end
    n_cmp += 4;
    if (nl != 1 || no != 0) begin n_bad++; $display("FAIL long_once got %0d long %0d other want 1 0", nl, no); end
    if (cl - 3 < 8 || cl - 3 > 11) begin n_bad++; $display("FAIL long_latency got %0d want 8..11", cl - 3); end
    if (hb != 0) begin n_bad++; $display("FAIL long_held got %0d low cycles want 0", hb); end
    if (obs_c[n] !== 8'd1) begin n_bad++; $display("FAIL long_count got %0d want 1", obs_c[n]); end
  endtask

  task automatic test_double();
    int nd = 0, ns = 0;
    add(0, 3);
    add(1, 2);
    add(0, 2);
    add(1, 2);
    add(0, 12);
    run_seq(0);
    for (int k = 0; k <= n; k++) begin
      if (obs_st[k][0]) nd++;
      if (obs_st[k][2]) ns++;
    end
    n_cmp += 3;
    if (obs_st[9] !== 3'b001) begin n_bad++; $display("FAIL double_at_2 got %b want 001", obs_st[9]); end
    if (nd != 1 || ns != 0) begin n_bad++; $display("FAIL double_only got %0d double %0d short want 1 0", nd, ns); end
    if (obs_c[n] !== 8'd1) begin n_bad++; $display("FAIL double_count got %0d want 1", obs_c[n]); end
  endtask

  task automatic test_gap_boundary();
    int ns = 0, nd = 0;
    add(0, 3);
    add(1, 2);
    add(0, 10);
    add(1, 2);
    add(0, 14);
    run_seq(0);
    for (int k = 0; k <= n; k++) begin
      if (obs_st[k][2]) ns++;
      if (obs_st[k][0]) nd++;
    end
    n_cmp += 2;
    if (ns != 2 || nd != 0) begin n_bad++; $display("FAIL gap_two_shorts got %0d short %0d double want 2 0", ns, nd); end
    if (obs_c[n] !== 8'd2) begin n_bad++; $display("FAIL gap_count got %0d want 2", obs_c[n]); end
  endtask

  task automatic test_wrap();
    add(0, 3);
    repeat (4) begin
      add(1, 2);
      add(0, 12);
    end
    run_seq(0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs_c2[3 + 14 * (i + 1)] !== 2'((i + 1) % 4)) begin
        n_bad++;
        $display("FAIL wrap_%0d got %0d want %0d", i, obs_c2[3 + 14 * (i + 1)], (i + 1) % 4);
      end
    end
  endtask

  task automatic test_random();
    bit init, lv;
    repeat (15) begin
      init = 1'($urandom_range(0, 1));
      lv = init;
      for (int j = 0; j < int'($urandom_range(3, 12)); j++) begin
        add(lv, int'($urandom_range(1, 14)));
        lv = !lv;
      end
      add(0, 16);
      run_seq(init);
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double();
    test_gap_boundary();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
